// File: rtl/tally_reporter.sv
// Tally reporter: on request, snapshots four 8-bit candidate tallies and
// sends them as a 6-byte UART 8N1 frame: 0xA5, cand1..cand4, checksum.
// The checksum is the modulo-256 sum of the snapshot tallies.
module tally_reporter #(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] cand1_votes,
  input  logic [7:0] cand2_votes,
  input  logic [7:0] cand3_votes,
  input  logic [7:0] cand4_votes,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

  localparam int unsigned      CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  // Modulo-256 sum of the four snapshot tallies.
  function automatic logic [7:0] checksum8(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d);
    logic [7:0] sum;
    sum = a + b + c + d;
    return sum;
  endfunction

  state_t           state_r;
  logic [2:0]       byte_idx_r;
  logic [2:0]       bit_idx_r;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       snap1_r;
  logic [7:0]       snap2_r;
  logic [7:0]       snap3_r;
  logic [7:0]       snap4_r;
  logic             tx_r;
  logic             busy_r;
  logic             done_r;

  logic [7:0]       checksum_s;
  logic [7:0]       cur_byte_s;
  logic [2:0]       next_bit_s;
  logic             bit_end_s;

  assign checksum_s = checksum8(snap1_r, snap2_r, snap3_r, snap4_r);
  assign next_bit_s = bit_idx_r + 3'd1;
  assign bit_end_s  = (cnt_r == CNT_MAX);

  // Select the frame byte addressed by the current byte index.
  always_comb begin
    cur_byte_s = 8'h00;
    case (byte_idx_r)
      3'd0:    cur_byte_s = 8'hA5;
      3'd1:    cur_byte_s = snap1_r;
      3'd2:    cur_byte_s = snap2_r;
      3'd3:    cur_byte_s = snap3_r;
      3'd4:    cur_byte_s = snap4_r;
      3'd5:    cur_byte_s = checksum_s;
      default: cur_byte_s = 8'h00;
    endcase
  end

  // Frame sequencer; tx/busy/done are registered alongside the state so the
  // line level always reflects the bit currently being held.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      byte_idx_r <= 3'd0;
      bit_idx_r  <= 3'd0;
      cnt_r      <= CNT_ZERO;
      snap1_r    <= 8'h00;
      snap2_r    <= 8'h00;
      snap3_r    <= 8'h00;
      snap4_r    <= 8'h00;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          tx_r   <= 1'b1;
          busy_r <= 1'b0;
          cnt_r  <= CNT_ZERO;
          if (start) begin
            snap1_r    <= cand1_votes;
            snap2_r    <= cand2_votes;
            snap3_r    <= cand3_votes;
            snap4_r    <= cand4_votes;
            byte_idx_r <= 3'd0;
            bit_idx_r  <= 3'd0;
            state_r    <= START_BIT;
            tx_r       <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        START_BIT: begin
          if (bit_end_s) begin
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            tx_r      <= cur_byte_s[0];
            state_r   <= DATA_BITS;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DATA_BITS: begin
          if (bit_end_s) begin
            cnt_r <= CNT_ZERO;
            if (bit_idx_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= STOP_BIT;
            end else begin
              bit_idx_r <= next_bit_s;
              tx_r      <= cur_byte_s[next_bit_s];
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        STOP_BIT: begin
          if (bit_end_s) begin
            cnt_r <= CNT_ZERO;
            if (byte_idx_r == 3'd5) begin
              state_r <= IDLE;
              tx_r    <= 1'b1;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              byte_idx_r <= byte_idx_r + 3'd1;
              tx_r       <= 1'b0;
              state_r    <= START_BIT;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign tx   = tx_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_tally_reporter.sv
// Self-checking bench for tally_reporter with CLKS_PER_BIT=4. The expected
// line level for every frame cycle is derived arithmetically from the frame
// byte list (start bit, 8 data bits LSB first, stop bit, each 4 cycles).
module tb_tally_reporter;

  localparam int CPB   = 4;
  localparam int FRAME = 60 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] c1 = 8'd0;
  logic [7:0] c2 = 8'd0;
  logic [7:0] c3 = 8'd0;
  logic [7:0] c4 = 8'd0;
  logic       tx;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  tally_reporter #(.CLKS_PER_BIT(CPB)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .cand1_votes (c1),
    .cand2_votes (c2),
    .cand3_votes (c3),
    .cand4_votes (c4),
    .tx          (tx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with start=1 already driven; returns at the
  // negedge of the done cycle, after checking it.
  task automatic run_frame(input bit hold, input int change_at, input logic [31:0] new_t,
                           input int pulse_at);
    int fb[6];
    int b, pos, e, sum;
    sum   = c1 + c2 + c3 + c4;
    fb[0] = 'hA5;
    fb[1] = c1;
    fb[2] = c2;
    fb[3] = c3;
    fb[4] = c4;
    fb[5] = sum % 256;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clock);
      if (c == 0 && !hold) start = 1'b0;
      if (c == change_at) {c4, c3, c2, c1} = new_t;
      if (c == pulse_at) start = 1'b1;
      if (c == pulse_at + 1 && !hold) start = 1'b0;
      b   = c / (10 * CPB);
      pos = (c % (10 * CPB)) / CPB;
      if (pos == 0)      e = 0;
      else if (pos == 9) e = 1;
      else               e = (fb[b] >> (pos - 1)) & 1;
      chk($sformatf("tx byte%0d pos%0d cyc%0d", b, pos, c), {31'd0, tx}, e);
      chk($sformatf("busy cyc%0d", c), {31'd0, busy}, 32'd1);
      chk($sformatf("done cyc%0d", c), {31'd0, done}, 32'd0);
    end
    @(negedge clock);
    chk("done_cycle done", {31'd0, done}, 32'd1);
    chk("done_cycle busy", {31'd0, busy}, 32'd0);
    chk("done_cycle tx",   {31'd0, tx},   32'd1);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clock);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " done"}, {31'd0, done}, 32'd0);
    chk({tag, " tx"},   {31'd0, tx},   32'd1);
  endtask

  initial begin
    int done_seen;
    int busy_seen;

    // Reset with start held high: reset wins.
    reset = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("reset tx",   {31'd0, tx},   32'd1);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
    end
    reset = 1'b0;
    start = 1'b0;
    check_idle("post_reset");

    // Directed: 3,0,255,7 with a one-cycle start.
    {c4, c3, c2, c1} = {8'd7, 8'd255, 8'd0, 8'd3};
    start = 1'b1;
    run_frame(1'b0, -1, 32'd0, -1);
    check_idle("after_frame1");

    // Directed: tallies change to 1,1,1,1 at frame cycle 20.
    {c4, c3, c2, c1} = {8'd7, 8'd255, 8'd0, 8'd3};
    start = 1'b1;
    run_frame(1'b0, 20, 32'h01010101, -1);
    check_idle("after_change");

    // Directed: checksum wrap-around.
    {c4, c3, c2, c1} = 32'hFFFFFFFF;
    start = 1'b1;
    run_frame(1'b0, -1, 32'd0, -1);
    check_idle("after_wrap");

    // Random tallies with random mid-frame changes and start pulses while busy.
    for (int k = 0; k < 4; k++) begin
      {c4, c3, c2, c1} = $urandom;
      start = 1'b1;
      run_frame(1'b0, $urandom_range(1, 230), $urandom, $urandom_range(1, 230));
      check_idle($sformatf("after_rand%0d", k));
    end

    // Held start: three back-to-back frames, fresh tallies for each.
    {c4, c3, c2, c1} = $urandom;
    start = 1'b1;
    run_frame(1'b1, -1, 32'd0, -1);
    {c4, c3, c2, c1} = $urandom;
    run_frame(1'b1, -1, 32'd0, -1);
    {c4, c3, c2, c1} = $urandom;
    run_frame(1'b0, -1, 32'd0, -1);
    check_idle("after_hold");

    // Reset at frame cycle 100 aborts without a done pulse.
    {c4, c3, c2, c1} = $urandom;
    start = 1'b1;
    for (int c = 0; c <= 100; c++) begin
      @(negedge clock);
      if (c == 0) start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    chk("abort tx",   {31'd0, tx},   32'd1);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    done_seen = 0;
    busy_seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (done === 1'b1) done_seen++;
      if (busy === 1'b1) busy_seen++;
    end
    chk("abort no_done", done_seen, 32'd0);
    chk("abort no_busy", busy_seen, 32'd0);

    // First start after reset gives a complete frame.
    {c4, c3, c2, c1} = $urandom;
    start = 1'b1;
    run_frame(1'b0, -1, 32'd0, -1);
    check_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tally_reporter.md
TALLY_REPORTER -- requirements
Module: tally_reporter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10, clock cycles per serial bit; legal range 2..65535.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  report request, sampled each rising edge.
REQ-005 cand1_votes  input  8  candidate 1 tally.
REQ-006 cand2_votes  input  8  candidate 2 tally.
REQ-007 cand3_votes  input  8  candidate 3 tally.
REQ-008 cand4_votes  input  8  candidate 4 tally.
REQ-009 tx  output  1  serial line, UART 8N1, idle high.
REQ-010 busy  output  1  high while a frame is in transmission.
REQ-011 done  output  1  one-cycle pulse after the final stop bit of a frame.

Function
REQ-012 States SHALL be IDLE, START_BIT, DATA_BITS, STOP_BIT; byte index 0..5 and bit index 0..7 SHALL be held in registers.
REQ-013 In IDLE, tx SHALL be 1 and busy SHALL be 0.
REQ-014 start=1 sampled in IDLE SHALL snapshot all four tallies and enter START_BIT with byte index 0.
REQ-015 The first start-bit cycle (tx=0, busy=1) SHALL be the cycle immediately after the edge that accepted start.
REQ-016 start SHALL be ignored when not in IDLE; a held start SHALL NOT retrigger until done has pulsed and IDLE is re-entered.
REQ-017 The frame SHALL be 6 bytes, in order: 0xA5, cand1, cand2, cand3, cand4, checksum.
REQ-018 Checksum SHALL be (cand1+cand2+cand3+cand4) mod 256, computed from snapshot values.
REQ-019 Each byte SHALL be sent as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-020 Bytes SHALL follow back-to-back with no idle gap; a frame SHALL last exactly 60*CLKS_PER_BIT cycles.
REQ-021 Tally input changes after the snapshot edge SHALL NOT affect the frame in progress.
REQ-022 After the last stop-bit cycle of byte 5, the FSM SHALL return to IDLE, with done=1 and busy=0 for exactly that first IDLE cycle.
REQ-023 start=1 in the done cycle SHALL be accepted and SHALL start a new frame; the next start bit SHALL begin the following cycle.
REQ-024 The tx, busy and done outputs SHALL be registered, with no combinational path from any input.
REQ-025 The bit-period counter SHALL be sized for CLKS_PER_BIT-1 and SHALL wrap to 0 at each bit boundary.

Reset
REQ-026 While reset=1: tx=1, busy=0, done=0, state=IDLE, all indices, counters and snapshot registers = 0.
REQ-027 Reset SHALL take priority over start.
REQ-028 Reset mid-frame SHALL abort the frame with tx=1 the next cycle and no done pulse.
REQ-029 The first start accepted after reset deasserts SHALL produce a complete frame.

Verification (CLKS_PER_BIT=4)
REQ-030 Tallies 3,0,255,7 and a 1-cycle start -> tx bytes A5,03,00,FF,07,09; busy high 240 cycles; single done pulse.
REQ-031 Tallies change to 1,1,1,1 at cycle 20 of the frame -> transmitted bytes unchanged from the snapshot (A5,03,00,FF,07,09).
REQ-032 Tallies 255,255,255,255 -> checksum 0xFC (wrap-around); tx bytes A5,FF,FF,FF,FF,FC.
REQ-033 start held high continuously -> back-to-back frames; each start bit begins the cycle after a done pulse; no frame is truncated.
REQ-034 reset asserted at cycle 100 of a frame -> tx=1, busy=0 the next cycle; done never asserts; a later start gives a full correct frame.
REQ-035 start pulse while busy -> ignored; exactly one frame and one done pulse.
